// File: rtl/dm_pkg.sv
// Shared types and constants for the data-memory responder.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package dm_pkg;

    localparam int DM_WORD_W = 32;
    localparam int DM_BE_W   = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } dm_state_t;

    // Store trace line: pc, word-aligned byte address, merged word.
    localparam string DM_TRACE_FMT = "@%h: *%h <= %h";

endpackage

// File: rtl/dm_responder_if.sv
// Load/store port between the CPU (master) and the data memory (slave).
// Latency: n/a (wires only).
// Backpressure: valid/ready on both the request and the response channel.
interface dm_responder_if;
    import dm_pkg::*;

    logic                 req_valid;
    logic                 req_ready;
    logic                 req_we;
    logic [DM_BE_W-1:0]   req_be;
    logic [DM_WORD_W-1:0] req_addr;
    logic [DM_WORD_W-1:0] req_wdata;
    logic [DM_WORD_W-1:0] req_pc;
    logic                 rsp_valid;
    logic                 rsp_ready;
    logic [DM_WORD_W-1:0] rsp_rdata;
    logic                 rsp_err;

    modport master (
        output req_valid, req_we, req_be, req_addr, req_wdata, req_pc, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_we, req_be, req_addr, req_wdata, req_pc, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );

endinterface

// File: rtl/dm_byte_merge.sv
// Replaces the byte lanes of a word selected by a byte-enable mask.
// Latency: combinational.
// Backpressure: none.
module dm_byte_merge
    import dm_pkg::*;
(
    input  logic [DM_WORD_W-1:0] old_word,
    input  logic [DM_WORD_W-1:0] wdata,
    input  logic [DM_BE_W-1:0]   be,
    output logic [DM_WORD_W-1:0] merged
);

    // Each enabled lane takes the new byte, the rest keep the stored byte.
    always_comb begin
        merged = old_word;
        for (int i = 0; i < DM_BE_W; i++) begin
            if (be[i]) begin
                merged[8*i +: 8] = wdata[8*i +: 8];
            end
        end
    end

endmodule

// File: rtl/dm_responder.sv
// Data-memory responder: one serialised load/store with WAIT_CYC wait states (optional store trace: DM_TRACE_EN).
// Latency: accept at edge N, rsp_valid high after edge N+WAIT_CYC+1.
// Backpressure: req_ready low outside IDLE; response held stable until rsp_ready.
module dm_responder
    import dm_pkg::*;
#(
    parameter int DEPTH_LOG2 = 10,
    parameter int WAIT_CYC   = 2
) (
    input  logic           clk,
    input  logic           reset,
    dm_responder_if.slave  bus
);

    localparam int         DEPTH     = 1 << DEPTH_LOG2;
    // The counter is loaded with WAIT_CYC and WAIT is left once it reads 0,
    // so WAIT always lasts WAIT_CYC+1 cycles (one cycle even for WAIT_CYC=0).
    localparam logic [3:0] WAIT_LOAD = 4'(WAIT_CYC);

    dm_state_t               state_q, state_n;
    logic [3:0]              cnt_q;
    logic                    cap_we;
    logic [DM_BE_W-1:0]      cap_be;
    logic [DM_WORD_W-1:0]    cap_addr;
    logic [DM_WORD_W-1:0]    cap_wdata;
    logic [DM_WORD_W-1:0]    rdata_q;
    logic                    err_q;
    logic [DM_WORD_W-1:0]    mem [DEPTH];

    logic                    enter_resp;
    logic                    addr_err;
    logic [DEPTH_LOG2-1:0]   idx;
    logic [DM_WORD_W-1:0]    merged;

    assign enter_resp = (state_q == WAIT) && (cnt_q == 4'd0);
    assign addr_err   = (cap_addr[1:0] != 2'b00) ||
                        ({2'b00, cap_addr[31:2]} >= 32'(DEPTH));
    assign idx        = cap_addr[DEPTH_LOG2+1:2];

    dm_byte_merge u_merge (
        .old_word (mem[idx]),
        .wdata    (cap_wdata),
        .be       (cap_be),
        .merged   (merged)
    );

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_q <= IDLE;
        else        state_q <= state_n;
    end

    // Next-state and handshake outputs.
    always_comb begin
        state_n       = state_q;
        bus.req_ready = 1'b0;
        bus.rsp_valid = 1'b0;
        case (state_q)
            IDLE: begin
                bus.req_ready = 1'b1;
                if (bus.req_valid) state_n = WAIT;
            end
            WAIT: begin
                if (cnt_q == 4'd0) state_n = RESP;
            end
            RESP: begin
                bus.rsp_valid = 1'b1;
                if (bus.rsp_ready) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    assign bus.rsp_rdata = rdata_q;
    assign bus.rsp_err   = err_q;

    // Request capture, wait counter and the registered response.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q     <= 4'd0;
            cap_we    <= 1'b0;
            cap_be    <= '0;
            cap_addr  <= '0;
            cap_wdata <= '0;
            rdata_q   <= '0;
            err_q     <= 1'b0;
        end else begin
            if (state_q == IDLE && bus.req_valid) begin
                cnt_q     <= WAIT_LOAD;
                cap_we    <= bus.req_we;
                cap_be    <= bus.req_be;
                cap_addr  <= bus.req_addr;
                cap_wdata <= bus.req_wdata;
            end else if (state_q == WAIT && cnt_q != 4'd0) begin
                cnt_q <= cnt_q - 4'd1;
            end
            if (enter_resp) begin
                err_q   <= addr_err;
                rdata_q <= (!addr_err && !cap_we) ? mem[idx] : '0;
            end else if (state_q == RESP && bus.rsp_ready) begin
                err_q   <= 1'b0;
                rdata_q <= '0;
            end
        end
    end

    // Memory array: written only on the edge that enters RESP.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mem <= '{default: '0};
        end else if (enter_resp && !addr_err && cap_we) begin
            mem[idx] <= merged;
        end
    end

`ifdef DM_TRACE_EN
    logic [DM_WORD_W-1:0] cap_pc;

    // PC is only needed for the trace line.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)                            cap_pc <= '0;
        else if (state_q == IDLE && bus.req_valid) cap_pc <= bus.req_pc;
    end

    // One trace line per store that actually changes lanes.
    always_ff @(posedge clk) begin
        if (reset && enter_resp && !addr_err && cap_we && cap_be != '0) begin
            $display(DM_TRACE_FMT, cap_pc, {cap_addr[31:2], 2'b00}, merged);
        end
    end
`endif

endmodule

// File: tb/tb_dm_responder.sv
module tb_dm_responder;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    dm_responder_if dif ();
    dm_responder_if dif0 ();

    dm_responder #(.DEPTH_LOG2(10), .WAIT_CYC(2)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (dif.slave)
    );

    dm_responder #(.DEPTH_LOG2(10), .WAIT_CYC(0)) dut0 (
        .clk   (clk),
        .reset (reset),
        .bus   (dif0.slave)
    );

    int checks = 0;
    int errors = 0;
    logic [31:0] model [1024];

    // Reference: memory is an array of words; addresses are bytes.
    task automatic model_apply(input bit we, input logic [3:0] be, input logic [31:0] addr,
                               input logic [31:0] wdata, output logic [31:0] rd, output logic er);
        int unsigned word;
        word = addr / 4;
        er = (addr % 4 != 0) || (word >= 1024);
        rd = 32'h0;
        if (!er) begin
            if (we) begin
                for (int b = 0; b < 4; b++)
                    if (be[b]) model[word][8*b +: 8] = wdata[8*b +: 8];
            end else begin
                rd = model[word];
            end
        end
    endtask

    // Drives one request on the WAIT_CYC=2 instance and collects its response.
    task automatic do_access(input bit we, input logic [3:0] be, input logic [31:0] addr,
                             input logic [31:0] wdata, input logic [31:0] pc,
                             output logic [31:0] rdata, output logic err, output int lat);
        int guard = 0;
        dif.req_we = we; dif.req_be = be; dif.req_addr = addr;
        dif.req_wdata = wdata; dif.req_pc = pc; dif.req_valid = 1'b1;
        while (!dif.req_ready && guard < 50) begin @(posedge clk); #1; guard++; end
        @(posedge clk); #1;
        dif.req_valid = 1'b0;
        dif.req_addr = $urandom; dif.req_wdata = $urandom;
        dif.req_be = 4'($urandom); dif.req_we = 1'($urandom);
        lat = 0;
        while (!dif.rsp_valid && lat < 100) begin @(posedge clk); #1; lat++; end
        rdata = dif.rsp_rdata;
        err = dif.rsp_err;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        logic [31:0] rd; logic er; int lat;
        reset = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;
        foreach (model[i]) model[i] = 32'h0;
        checks++; if (dif.req_ready !== 1'b1) begin errors++; $display("FAIL reset_req_ready got %b want 1", dif.req_ready); end
        checks++; if (dif.rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid got %b want 0", dif.rsp_valid); end
        checks++; if (dif.rsp_rdata !== 32'h0) begin errors++; $display("FAIL reset_rsp_rdata got %h want 0", dif.rsp_rdata); end
        checks++; if (dif.rsp_err !== 1'b0) begin errors++; $display("FAIL reset_rsp_err got %b want 0", dif.rsp_err); end
        do_access(1'b0, 4'h0, 32'h0, 32'h0, 32'h0, rd, er, lat);
        checks++; if (rd !== 32'h0 || er !== 1'b0) begin errors++; $display("FAIL reset_load0 got %h/%b want 00000000/0", rd, er); end
    endtask

    task automatic test_store_load();
        logic [31:0] rd; logic er; int lat;
        do_access(1'b1, 4'hF, 32'h10, 32'hDEADBEEF, 32'h3000, rd, er, lat);
        checks++; if (lat !== 3) begin errors++; $display("FAIL store_latency got %0d want 3", lat); end
        checks++; if (rd !== 32'h0 || er !== 1'b0) begin errors++; $display("FAIL store_rsp got %h/%b want 00000000/0", rd, er); end
        checks++; if (dif.rsp_valid !== 1'b0 || dif.req_ready !== 1'b1) begin errors++; $display("FAIL store_consumed got valid %b ready %b want 0 1", dif.rsp_valid, dif.req_ready); end
        checks++; if (dif.rsp_rdata !== 32'h0) begin errors++; $display("FAIL rdata_cleared got %h want 0", dif.rsp_rdata); end
        do_access(1'b0, 4'h0, 32'h10, 32'h0, 32'h0, rd, er, lat);
        checks++; if (rd !== 32'hDEADBEEF || er !== 1'b0 || lat !== 3) begin errors++; $display("FAIL load_10 got %h/%b lat %0d want deadbeef/0 lat 3", rd, er, lat); end
    endtask

    task automatic test_byte_merge();
        logic [31:0] rd; logic er; int lat;
        do_access(1'b1, 4'hF, 32'h20, 32'h11223344, 32'h0, rd, er, lat);
        do_access(1'b1, 4'b0101, 32'h20, 32'hAABBCCDD, 32'h0, rd, er, lat);
        checks++; if (er !== 1'b0) begin errors++; $display("FAIL merge_store_err got %b want 0", er); end
        do_access(1'b0, 4'h0, 32'h20, 32'h0, 32'h0, rd, er, lat);
        checks++; if (rd !== 32'h11BB33DD) begin errors++; $display("FAIL byte_merge got %h want 11bb33dd", rd); end
        do_access(1'b1, 4'h0, 32'h20, 32'hFFFFFFFF, 32'h0, rd, er, lat);
        checks++; if (er !== 1'b0) begin errors++; $display("FAIL be0_err got %b want 0", er); end
        do_access(1'b0, 4'h0, 32'h20, 32'h0, 32'h0, rd, er, lat);
        checks++; if (rd !== 32'h11BB33DD) begin errors++; $display("FAIL be0_noop got %h want 11bb33dd", rd); end
    endtask

    task automatic test_errors();
        logic [31:0] rd; logic er; int lat;
        do_access(1'b0, 4'hF, 32'h13, 32'h0, 32'h0, rd, er, lat);
        checks++; if (er !== 1'b1 || rd !== 32'h0) begin errors++; $display("FAIL misaligned got %h/%b want 00000000/1", rd, er); end
        do_access(1'b1, 4'hF, 32'h1000, 32'hCAFEF00D, 32'h0, rd, er, lat);
        checks++; if (er !== 1'b1 || rd !== 32'h0) begin errors++; $display("FAIL out_of_range got %h/%b want 00000000/1", rd, er); end
        do_access(1'b0, 4'h0, 32'h0, 32'h0, 32'h0, rd, er, lat);
        checks++; if (rd !== 32'h0 || er !== 1'b0) begin errors++; $display("FAIL oor_no_alias got %h/%b want 00000000/0", rd, er); end
        do_access(1'b1, 4'hF, 32'hFFC, 32'h5A5A1234, 32'h0, rd, er, lat);
        do_access(1'b0, 4'h0, 32'hFFC, 32'h0, 32'h0, rd, er, lat);
        checks++; if (rd !== 32'h5A5A1234 || er !== 1'b0) begin errors++; $display("FAIL last_word got %h/%b want 5a5a1234/0", rd, er); end
    endtask

    task automatic test_backpressure();
        logic [31:0] rd; logic er; int lat; int guard;
        dif.rsp_ready = 1'b0;
        dif.req_we = 1'b0; dif.req_be = 4'h0; dif.req_addr = 32'h10; dif.req_valid = 1'b1;
        @(posedge clk); #1;
        dif.req_valid = 1'b0;
        guard = 0;
        while (!dif.rsp_valid && guard < 100) begin @(posedge clk); #1; guard++; end
        checks++; if (dif.rsp_valid !== 1'b1) begin errors++; $display("FAIL bp_resp_timeout got valid %b want 1", dif.rsp_valid); end
        // A competing store that must not be taken while the response waits.
        dif.req_we = 1'b1; dif.req_be = 4'hF; dif.req_addr = 32'h10; dif.req_wdata = 32'h0; dif.req_valid = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
            checks++;
            if (dif.rsp_valid !== 1'b1 || dif.rsp_rdata !== 32'hDEADBEEF || dif.req_ready !== 1'b0) begin
                errors++;
                $display("FAIL bp_hold cycle %0d got valid %b rdata %h ready %b want 1 deadbeef 0", c, dif.rsp_valid, dif.rsp_rdata, dif.req_ready);
            end
        end
        dif.req_valid = 1'b0;
        dif.rsp_ready = 1'b1;
        @(posedge clk); #1;
        checks++; if (dif.rsp_valid !== 1'b0 || dif.req_ready !== 1'b1 || dif.rsp_rdata !== 32'h0) begin errors++; $display("FAIL bp_release got valid %b ready %b rdata %h want 0 1 0", dif.rsp_valid, dif.req_ready, dif.rsp_rdata); end
        do_access(1'b0, 4'h0, 32'h10, 32'h0, 32'h0, rd, er, lat);
        checks++; if (rd !== 32'hDEADBEEF) begin errors++; $display("FAIL bp_store_ignored got %h want deadbeef", rd); end
    endtask

    task automatic test_back_to_back();
        int acc = 0; int guard = 0;
        dif.req_we = 1'b0; dif.req_be = 4'h0; dif.req_addr = 32'h10; dif.req_valid = 1'b1;
        for (int c = 0; c < 16; c++) begin
            if (dif.req_ready) acc++;
            @(posedge clk); #1;
        end
        dif.req_valid = 1'b0;
        while (!(dif.req_ready && !dif.rsp_valid) && guard < 50) begin @(posedge clk); #1; guard++; end
        checks++; if (acc !== 4) begin errors++; $display("FAIL throughput got %0d accepts want 4", acc); end
    endtask

    task automatic test_reset_mid();
        logic [31:0] rd; logic er; int lat;
        dif.req_we = 1'b1; dif.req_be = 4'hF; dif.req_addr = 32'h40; dif.req_wdata = 32'h55AA55AA; dif.req_valid = 1'b1;
        @(posedge clk); #1;
        dif.req_valid = 1'b0;
        @(posedge clk); #1;
        checks++; if (dif.req_ready !== 1'b0 || dif.rsp_valid !== 1'b0) begin errors++; $display("FAIL mid_in_wait got ready %b valid %b want 0 0", dif.req_ready, dif.rsp_valid); end
        reset = 1'b0;
        #2;
        checks++; if (dif.req_ready !== 1'b1) begin errors++; $display("FAIL async_reset got ready %b want 1", dif.req_ready); end
        @(posedge clk); #1;
        reset = 1'b1;
        foreach (model[i]) model[i] = 32'h0;
        do_access(1'b0, 4'h0, 32'h40, 32'h0, 32'h0, rd, er, lat);
        checks++; if (rd !== 32'h0 || er !== 1'b0) begin errors++; $display("FAIL mid_reset_load got %h/%b want 00000000/0", rd, er); end
    endtask

    task automatic test_wait0();
        bit          we_t [2]    = '{1'b1, 1'b0};
        logic [31:0] exp_rd [2]  = '{32'h0, 32'hDEADBEEF};
        int lat; int guard;
        for (int k = 0; k < 2; k++) begin
            dif0.req_we = we_t[k]; dif0.req_be = 4'hF; dif0.req_addr = 32'h10;
            dif0.req_wdata = 32'hDEADBEEF; dif0.req_pc = 32'h3000; dif0.req_valid = 1'b1;
            guard = 0;
            while (!dif0.req_ready && guard < 50) begin @(posedge clk); #1; guard++; end
            @(posedge clk); #1;
            dif0.req_valid = 1'b0;
            lat = 0;
            while (!dif0.rsp_valid && lat < 100) begin @(posedge clk); #1; lat++; end
            checks++; if (lat !== 1) begin errors++; $display("FAIL wait0_latency op %0d got %0d want 1", k, lat); end
            checks++; if (dif0.rsp_rdata !== exp_rd[k] || dif0.rsp_err !== 1'b0) begin errors++; $display("FAIL wait0_data op %0d got %h/%b want %h/0", k, dif0.rsp_rdata, dif0.rsp_err, exp_rd[k]); end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_random();
        logic [31:0] rd, exp_rd; logic er, exp_er; int lat;
        bit we; logic [3:0] be; logic [31:0] addr, wdata;
        for (int n = 0; n < 60; n++) begin
            we = 1'($urandom);
            be = 4'($urandom);
            wdata = $urandom;
            case ($urandom_range(0, 7))
                0:       addr = ($urandom_range(0, 15) * 4) + $urandom_range(1, 3);
                1:       addr = 32'h1000 + ($urandom_range(0, 255) * 4);
                default: addr = $urandom_range(0, 15) * 4;
            endcase
            model_apply(we, be, addr, wdata, exp_rd, exp_er);
            do_access(we, be, addr, wdata, $urandom, rd, er, lat);
            checks++; if (rd !== exp_rd) begin errors++; $display("FAIL rand_rdata #%0d addr %h got %h want %h", n, addr, rd, exp_rd); end
            checks++; if (er !== exp_er) begin errors++; $display("FAIL rand_err #%0d addr %h got %b want %b", n, addr, er, exp_er); end
            checks++; if (lat !== 3) begin errors++; $display("FAIL rand_latency #%0d got %0d want 3", n, lat); end
        end
    endtask

    initial begin
        dif.req_valid = 1'b0; dif.req_we = 1'b0; dif.req_be = 4'h0;
        dif.req_addr = 32'h0; dif.req_wdata = 32'h0; dif.req_pc = 32'h0; dif.rsp_ready = 1'b1;
        dif0.req_valid = 1'b0; dif0.req_we = 1'b0; dif0.req_be = 4'h0;
        dif0.req_addr = 32'h0; dif0.req_wdata = 32'h0; dif0.req_pc = 32'h0; dif0.rsp_ready = 1'b1;
        test_reset();
        test_store_load();
        test_byte_merge();
        test_errors();
        test_backpressure();
        test_back_to_back();
        test_reset_mid();
        test_wait0();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
